// File: rtl/conv_pass_scheduler_if.sv
// ============================================================================
// Module   : conv_pass_scheduler_if
// Desc     : Host/PE handshake bundle for the convolution pass scheduler.
//            The slave side is the scheduler; the master side is whatever
//            drives job requests and reports buffer/PE status.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface conv_pass_scheduler_if #(
    parameter int TILE_W = 8
);
    // host request and control
    logic              start;
    logic              abort;
    logic [1:0]        cfg_ci;
    logic [1:0]        cfg_co;
    logic [TILE_W-1:0] cfg_tiles;

    // buffer and PE status
    logic              ifm_buf_ready;
    logic              wgt_buf_ready;
    logic              pass_done;
    logic              end_conv;

    // scheduler outputs
    logic [1:0]        pe_cfg_ci;
    logic [1:0]        pe_cfg_co;
    logic              start_conv;
    logic              start_again;
    logic              buf_release;
    logic [TILE_W-1:0] tile_idx;
    logic [1:0]        co_idx;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, abort, cfg_ci, cfg_co, cfg_tiles,
        output ifm_buf_ready, wgt_buf_ready, pass_done, end_conv,
        input  pe_cfg_ci, pe_cfg_co, start_conv, start_again, buf_release,
        input  tile_idx, co_idx, busy, done, err
    );

    modport slave (
        input  start, abort, cfg_ci, cfg_co, cfg_tiles,
        input  ifm_buf_ready, wgt_buf_ready, pass_done, end_conv,
        output pe_cfg_ci, pe_cfg_co, start_conv, start_again, buf_release,
        output tile_idx, co_idx, busy, done, err
    );
endinterface

`default_nettype wire

// File: rtl/conv_pass_scheduler.sv
// ============================================================================
// Module   : conv_pass_scheduler
// Desc     : Job-level sequencer in front of the PE control FSM. Issues one
//            configuration pulse per job, one launch pulse per output-channel
//            pass (gated on buffer readiness) and a final flush launch, then
//            waits for the PE to finish. Includes a pass/finish watchdog and
//            a synchronous abort.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_pass_scheduler #(
    parameter int TILE_W      = 8,
    parameter int TIMEOUT_CYC = 4096,
    parameter int WD_W        = 13
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    conv_pass_scheduler_if.slave sched
);

    // The watchdog trips on the cycle whose increment would reach TIMEOUT_CYC.
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        CFG      = 4'd1,
        WAIT_BUF = 4'd2,
        ISSUE    = 4'd3,
        RUN      = 4'd4,
        FLUSH    = 4'd5,
        WAIT_END = 4'd6,
        DONE     = 4'd7,
        ERR      = 4'd8
    } state_t;

    state_t            state;
    state_t            state_nxt;

    // job context latched at acceptance
    logic [1:0]        ci_hold;
    logic [1:0]        co_hold;
    logic [TILE_W-1:0] tiles_last;

    // progress and supervision
    logic [TILE_W-1:0] tile_cnt;
    logic [1:0]        co_cnt;
    logic [WD_W-1:0]   wd;
    logic              err_flag;

    // registered pulse/level outputs
    logic              start_conv_q;
    logic              start_again_q;
    logic              buf_release_q;
    logic              busy_q;
    logic              done_q;

    // decoded events
    logic              take_job;
    logic              take_empty;
    logic              pass_ack;
    logic              last_pass;
    logic              wd_expired;

    // Event decode and next-state selection; abort overrides everything.
    always_comb begin
        state_nxt  = state;
        take_job   = 1'b0;
        take_empty = 1'b0;
        pass_ack   = 1'b0;
        // tiles_last is cfg_tiles-1 captured at acceptance, so a full-range
        // tile count never needs a wider compare.
        last_pass  = (tile_cnt == tiles_last) && (co_cnt == co_hold);
        wd_expired = (wd == WD_LAST);

        if (sched.abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (sched.start) begin
                        if (sched.cfg_tiles == '0) begin
                            take_empty = 1'b1;
                            state_nxt  = DONE;
                        end else begin
                            take_job  = 1'b1;
                            state_nxt = CFG;
                        end
                    end
                end
                CFG:      state_nxt = WAIT_BUF;
                WAIT_BUF: begin
                    if (sched.ifm_buf_ready && sched.wgt_buf_ready) begin
                        state_nxt = ISSUE;
                    end
                end
                ISSUE:    state_nxt = RUN;
                RUN: begin
                    // pass_done beats a simultaneous watchdog expiry
                    if (sched.pass_done) begin
                        pass_ack  = 1'b1;
                        state_nxt = last_pass ? FLUSH : WAIT_BUF;
                    end else if (wd_expired) begin
                        state_nxt = ERR;
                    end
                end
                FLUSH:    state_nxt = WAIT_END;
                WAIT_END: begin
                    if (sched.end_conv) begin
                        state_nxt = DONE;
                    end else if (wd_expired) begin
                        state_nxt = ERR;
                    end
                end
                DONE:     state_nxt = IDLE;
                ERR:      state_nxt = IDLE;
                default:  state_nxt = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_conv_q  <= 1'b0;
            start_again_q <= 1'b0;
            buf_release_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            start_conv_q  <= (state_nxt == CFG);
            start_again_q <= (state_nxt == ISSUE) || (state_nxt == FLUSH);
            buf_release_q <= pass_ack;
            busy_q        <= (state_nxt != IDLE);
            done_q        <= (state_nxt == DONE);
        end
    end

    // Job context capture and tile/pass progress tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ci_hold    <= 2'd0;
            co_hold    <= 2'd0;
            tiles_last <= '0;
            tile_cnt   <= '0;
            co_cnt     <= 2'd0;
        end else if (take_job) begin
            ci_hold    <= sched.cfg_ci;
            co_hold    <= sched.cfg_co;
            tiles_last <= sched.cfg_tiles - TILE_W'(1);
            tile_cnt   <= '0;
            co_cnt     <= 2'd0;
        end else if (pass_ack && !last_pass) begin
            // the final pass leaves the indices on the last (tile, co) pair
            if (co_cnt == co_hold) begin
                co_cnt   <= 2'd0;
                tile_cnt <= tile_cnt + TILE_W'(1);
            end else begin
                co_cnt   <= co_cnt + 2'd1;
            end
        end
    end

    // Watchdog: cleared on each launch, counts while waiting on the PE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd <= '0;
        end else begin
            case (state)
                ISSUE, FLUSH:  wd <= '0;
                RUN, WAIT_END: wd <= wd + WD_W'(1);
                default:       wd <= wd;
            endcase
        end
    end

    // Sticky error: set on leaving ERR, cleared by the next accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_flag <= 1'b0;
        end else if ((state == ERR) && !sched.abort) begin
            err_flag <= 1'b1;
        end else if (take_job || take_empty) begin
            err_flag <= 1'b0;
        end
    end

    assign sched.pe_cfg_ci   = ci_hold;
    assign sched.pe_cfg_co   = co_hold;
    assign sched.start_conv  = start_conv_q;
    assign sched.start_again = start_again_q;
    assign sched.buf_release = buf_release_q;
    assign sched.tile_idx    = tile_cnt;
    assign sched.co_idx      = co_cnt;
    assign sched.busy        = busy_q;
    assign sched.done        = done_q;
    assign sched.err         = err_flag;

endmodule

`default_nettype wire
